// File: rtl/ip_wm_sram_1rw1r_model.sv
// Behavioural 1RW + 1R SRAM model: inputs captured on posedge, array accessed on negedge.
// Define SRAM_OUT_REG_EN to add a posedge output register on dout0/dout1 (2-cycle latency).
module ip_wm_sram_1rw1r_model #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter int WMASK_WIDTH = 8,
    parameter int NUM_WMASKS  = DATA_WIDTH / WMASK_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1
);

    if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
        $error("DATA_WIDTH must be an integer multiple of WMASK_WIDTH");
    end

    logic                  csb0_reg;
    logic                  web0_reg;
    logic [NUM_WMASKS-1:0] wmask0_reg;
    logic [ADDR_WIDTH-1:0] addr0_reg;
    logic [DATA_WIDTH-1:0] din0_reg;
    logic                  csb1_reg;
    logic [ADDR_WIDTH-1:0] addr1_reg;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] dout0_q;
    logic [DATA_WIDTH-1:0] dout1_q;

    logic rd0, wr0, rd1, oor0, oor1;

    // Async reset forces the chip selects high, which also cancels an op pending for the negedge.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            csb0_reg   <= 1'b1;
            web0_reg   <= 1'b1;
            wmask0_reg <= '0;
            addr0_reg  <= '0;
            din0_reg   <= '0;
            csb1_reg   <= 1'b1;
            addr1_reg  <= '0;
        end else begin
            csb0_reg   <= csb0;
            web0_reg   <= web0;
            wmask0_reg <= wmask0;
            addr0_reg  <= addr0;
            din0_reg   <= din0;
            csb1_reg   <= csb1;
            addr1_reg  <= addr1;
        end
    end

    always_comb begin
        rd0  = !csb0_reg && web0_reg;
        wr0  = !csb0_reg && !web0_reg;
        rd1  = !csb1_reg;
        oor0 = 32'(addr0_reg) >= RAM_DEPTH;
        oor1 = 32'(addr1_reg) >= RAM_DEPTH;
    end

    // Nonblocking update keeps port 1 read-before-write on a same-address collision.
    always_ff @(negedge clk0) begin
        if (wr0 && !oor0) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (wmask0_reg[i]) begin
                    mem[addr0_reg][i*WMASK_WIDTH +: WMASK_WIDTH] <=
                        din0_reg[i*WMASK_WIDTH +: WMASK_WIDTH];
                end
            end
        end
        if ((rd0 || wr0) && oor0) begin
            $warning("sram port0 address %0d beyond depth %0d", addr0_reg, RAM_DEPTH);
        end
        if (rd1 && oor1) begin
            $warning("sram port1 address %0d beyond depth %0d", addr1_reg, RAM_DEPTH);
        end
    end

    always_ff @(negedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            dout0_q <= '0;
            dout1_q <= '0;
        end else begin
            if (rd0) dout0_q <= oor0 ? '0 : mem[addr0_reg];
            if (rd1) dout1_q <= oor1 ? '0 : mem[addr1_reg];
        end
    end

`ifdef SRAM_OUT_REG_EN
    logic                  rd0_vld;
    logic                  rd1_vld;
    logic [DATA_WIDTH-1:0] dout0_oq;
    logic [DATA_WIDTH-1:0] dout1_oq;

    // Remembers whether the last negedge performed a read, so the output stage holds otherwise.
    always_ff @(negedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            rd0_vld <= 1'b0;
            rd1_vld <= 1'b0;
        end else begin
            rd0_vld <= rd0;
            rd1_vld <= rd1;
        end
    end

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            dout0_oq <= '0;
            dout1_oq <= '0;
        end else begin
            if (rd0_vld) dout0_oq <= dout0_q;
            if (rd1_vld) dout1_oq <= dout1_q;
        end
    end

    assign dout0 = dout0_oq;
    assign dout1 = dout1_oq;
`else
    assign dout0 = dout0_q;
    assign dout1 = dout1_q;
`endif

endmodule
